// File: rtl/jedro_1_data_ram.sv
// -----------------------------------------------------------------------------
// jedro_1_data_ram
// Word-organised data RAM with a strobe/ack bus and a programmable response
// latency. Each accepted request goes IDLE -> (WAIT) -> RESP. The response
// (ack_o or err_o) is a one-cycle pulse driven from a register during RESP.
//
// Parameters
//   MEM_WORDS   : depth in 32-bit words (power of two, 16..65536)
//   WAIT_STATES : extra cycles between the request and its response (0..7)
//
// Ports
//   clk_i   in  1  clock, rising edge
//   rstn_i  in  1  synchronous active-low reset
//   stb_i   in  1  request strobe, one-cycle pulse, honoured only in IDLE
//   addr_i  in  32 byte address
//   we_i    in  4  byte-lane write enables, 4'b0000 = read
//   wdata_i in  32 lane-aligned write data
//   rdata_o out 32 full addressed word, updated only by read responses
//   ack_o   out 1  completion pulse
//   err_o   out 1  bus-error pulse, never together with ack_o
//
// Build option
//   JEDRO_1_DRAM_RANGE_CHECK_EN : when defined, addresses at or above
//   MEM_WORDS*4 answer with err_o, write nothing and leave rdata_o alone.
//   When undefined, err_o stays 0 and the address wraps modulo MEM_WORDS*4.
// -----------------------------------------------------------------------------
module jedro_1_data_ram #(
    parameter int unsigned MEM_WORDS   = 1024,
    parameter int unsigned WAIT_STATES = 1
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        stb_i,
    input  logic [31:0] addr_i,
    input  logic [3:0]  we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] rdata_o,
    output logic        ack_o,
    output logic        err_o
);

    localparam int unsigned AW        = $clog2(MEM_WORDS);
    localparam logic [2:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t         state_r;
    state_t         state_s;
    logic [2:0]     wait_cnt_r;
    logic [2:0]     wait_cnt_s;
    logic [AW-1:0]  idx_r;
    logic [3:0]     we_r;
    logic [31:0]    wdata_r;
    logic           oor_r;
    logic [31:0]    rdata_r;
    logic           ack_r;
    logic           err_r;

    logic [AW-1:0]  idx_s;
    logic [3:0]     we_s;
    logic           oor_s;
    logic           addr_oor_s;
    logic           enter_resp_s;
    logic           unused_s;

    logic [31:0]    mem [MEM_WORDS];

`ifdef JEDRO_1_DRAM_RANGE_CHECK_EN
    localparam logic [32:0] MEM_BYTES = 33'(MEM_WORDS) * 33'd4;
    assign addr_oor_s = ({1'b0, addr_i} >= MEM_BYTES);
`else
    assign addr_oor_s = 1'b0;
`endif

    // Byte offset and (without range checking) high address bits are don't-care.
    assign unused_s = ^{addr_i[31:AW+2], addr_i[1:0]};

    // Next-state and wait-counter logic.
    always_comb begin
        state_s    = state_r;
        wait_cnt_s = wait_cnt_r;
        case (state_r)
            IDLE: begin
                if (stb_i) begin
                    if (WAIT_STATES > 0) begin
                        state_s    = WAIT;
                        wait_cnt_s = WAIT_LOAD;
                    end else begin
                        state_s = RESP;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            WAIT: begin
                if (wait_cnt_r == 3'd0) begin
                    state_s = RESP;
                end else begin
                    wait_cnt_s = wait_cnt_r - 3'd1;
                end
            end
            RESP: begin
                state_s = IDLE;
            end
            default: begin
                state_s    = IDLE;
                wait_cnt_s = 3'd0;
            end
        endcase
    end

    // Request attributes as seen on the edge that enters RESP: with zero wait
    // states that edge is also the accepting edge, so the live inputs are used.
    always_comb begin
        if (state_r == IDLE) begin
            idx_s = addr_i[AW+1:2];
            we_s  = we_i;
            oor_s = addr_oor_s;
        end else begin
            idx_s = idx_r;
            we_s  = we_r;
            oor_s = oor_r;
        end
    end

    assign enter_resp_s = (state_r != RESP) && (state_s == RESP);

    // FSM, request latch and registered bus outputs.
    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_r    <= IDLE;
            wait_cnt_r <= 3'd0;
            idx_r      <= {AW{1'b0}};
            we_r       <= 4'b0000;
            wdata_r    <= 32'h0000_0000;
            oor_r      <= 1'b0;
            rdata_r    <= 32'h0000_0000;
            ack_r      <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            state_r    <= state_s;
            wait_cnt_r <= wait_cnt_s;
            if ((state_r == IDLE) && stb_i) begin
                idx_r   <= addr_i[AW+1:2];
                we_r    <= we_i;
                wdata_r <= wdata_i;
                oor_r   <= addr_oor_s;
            end
            ack_r <= enter_resp_s && !oor_s;
            err_r <= enter_resp_s && oor_s;
            // Only an in-range read refreshes rdata; writes and errors hold it.
            if (enter_resp_s && (we_s == 4'b0000) && !oor_s) begin
                rdata_r <= mem[idx_s];
            end
        end
    end

    // Write commit at the end of RESP; a reset in that cycle drops the write.
    always_ff @(posedge clk_i) begin
        if (rstn_i && (state_r == RESP) && (we_r != 4'b0000) && !oor_r) begin
            for (int b = 0; b < 4; b++) begin
                if (we_r[b]) begin
                    mem[idx_r][8*b +: 8] <= wdata_r[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = rdata_r;
    assign ack_o   = ack_r;
    assign err_o   = err_r;

endmodule

// File: tb/tb_jedro_1_data_ram.sv
// -----------------------------------------------------------------------------
// Bench for jedro_1_data_ram. Three instances (WAIT_STATES 1, 2 and 0) share
// clock and reset. A reference memory per instance predicts each response at
// the moment a request is driven; the expectation (kind, cycle, rdata) is
// queued and compared when the instance pulses ack_o/err_o.
// -----------------------------------------------------------------------------
module tb_jedro_1_data_ram;

    localparam int NDUT  = 3;
    localparam int WORDS = 1024;

    typedef struct {
        logic        is_err;
        logic [31:0] rdata;
        int          cyc;
    } resp_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        stb   [NDUT];
    logic [31:0] addr  [NDUT];
    logic [3:0]  we    [NDUT];
    logic [31:0] wdata [NDUT];
    logic [31:0] rdata [NDUT];
    logic        ack   [NDUT];
    logic        err   [NDUT];

    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    resp_t       exp_q [NDUT][$];
    int          busy  [NDUT];
    logic [31:0] rd_model  [NDUT];
    logic [31:0] mem_model [NDUT][WORDS];
    resp_t       mon_e;

    always #5 clk = ~clk;

    // Cycle index: value during a period equals the number of edges so far.
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        jedro_1_data_ram #(
            .MEM_WORDS  (WORDS),
            .WAIT_STATES((g == 0) ? 1 : ((g == 1) ? 2 : 0))
        ) u_dut (
            .clk_i  (clk),
            .rstn_i (rstn),
            .stb_i  (stb[g]),
            .addr_i (addr[g]),
            .we_i   (we[g]),
            .wdata_i(wdata[g]),
            .rdata_o(rdata[g]),
            .ack_o  (ack[g]),
            .err_o  (err[g])
        );
    end

    function automatic int ws_of(input int d);
        return (d == 0) ? 1 : ((d == 1) ? 2 : 0);
    endfunction

    function automatic bit oor_of(input logic [31:0] a);
`ifdef JEDRO_1_DRAM_RANGE_CHECK_EN
        return (a >= 32'(WORDS * 4));
`else
        return 1'b0;
`endif
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Drive one request for one cycle, starting just after a rising edge.
    task automatic issue(input int d, input logic [31:0] a, input logic [3:0] w,
                         input logic [31:0] wd, input bit abort);
        resp_t    e;
        bit       oor;
        int       i;
        stb[d]   = 1'b1;
        addr[d]  = a;
        we[d]    = w;
        wdata[d] = wd;
        if (cyc >= busy[d]) begin
            busy[d] = cyc + 2 + ws_of(d);
            if (!abort) begin
                oor = oor_of(a);
                i   = int'(a[11:2]);
                if (!oor) begin
                    if (w == 4'b0000) begin
                        rd_model[d] = mem_model[d][i];
                    end else begin
                        for (int b = 0; b < 4; b++)
                            if (w[b]) mem_model[d][i][8*b +: 8] = wd[8*b +: 8];
                    end
                end
                e.is_err = oor;
                e.rdata  = rd_model[d];
                e.cyc    = cyc + 1 + ws_of(d);
                exp_q[d].push_back(e);
            end
        end
        @(posedge clk); #1;
        stb[d] = 1'b0;
        we[d]  = 4'b0000;
    endtask

    task automatic wait_idle(input int d);
        while (cyc < busy[d]) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic write_w(input int d, input logic [31:0] a, input logic [3:0] w, input logic [31:0] wd);
        wait_idle(d);
        issue(d, a, w, wd, 1'b0);
    endtask

    task automatic read_w(input int d, input logic [31:0] a);
        wait_idle(d);
        issue(d, a, 4'b0000, 32'h0, 1'b0);
    endtask

    // Scoreboard: every response must match the oldest queued expectation.
    always @(negedge clk) begin
        for (int d = 0; d < NDUT; d++) begin
            if (ack[d] && err[d]) check_eq("ack_err_excl", 32'd1, 32'd0);
            if (ack[d] || err[d]) begin
                if (exp_q[d].size() == 0) begin
                    check_eq("spurious_resp", 32'd1, 32'd0);
                end else begin
                    mon_e = exp_q[d].pop_front();
                    check_eq("resp_is_err", 32'(err[d]), 32'(mon_e.is_err));
                    check_eq("latency",     32'(cyc),    32'(mon_e.cyc));
                    check_eq("rdata",       rdata[d],    mon_e.rdata);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0;
        for (int d = 0; d < NDUT; d++) begin
            stb[d] = 1'b0; addr[d] = 32'h0; we[d] = 4'b0000; wdata[d] = 32'h0;
            busy[d] = 0; rd_model[d] = 32'h0;
        end
        repeat (2) @(posedge clk);
        #1;
        rstn = 1'b1;
        for (int d = 0; d < NDUT; d++) begin
            check_eq("rst_rdata", rdata[d], 32'h0);
            check_eq("rst_ack",   32'(ack[d]), 32'd0);
            check_eq("rst_err",   32'(err[d]), 32'd0);
        end

        // Full-word write then read, one wait state.
        write_w(0, 32'h10, 4'b1111, 32'hDEADBEEF);
        read_w (0, 32'h10);
        // Byte offset ignored for indexing.
        read_w (0, 32'h13);

        // Single-lane merge into an existing word.
        write_w(0, 32'h20, 4'b1111, 32'h11223344);
        write_w(0, 32'h22, 4'b0100, 32'h00AA0000);
        read_w (0, 32'h20);

        // Last word of the array.
        write_w(0, 32'hFFC, 4'b1111, 32'hA1B2C3D4);
        read_w (0, 32'hFFF);

        // Two lanes, read immediately after.
        write_w(0, 32'h24, 4'b1111, 32'h00000000);
        write_w(0, 32'h24, 4'b1001, 32'h5A0000C3);
        read_w (0, 32'h24);

        // Second strobe while busy is ignored (two wait states).
        write_w(1, 32'h34, 4'b1111, 32'h01010101);
        wait_idle(1);
        issue(1, 32'h30, 4'b1111, 32'hA5A5A5A5, 1'b0);
        issue(1, 32'h34, 4'b1111, 32'hFFFFFFFF, 1'b0);
        read_w (1, 32'h30);
        read_w (1, 32'h34);

        // Zero wait states: fill, then reads strobed every second cycle.
        write_w(2, 32'h40, 4'b1111, 32'h40404040);
        write_w(2, 32'h44, 4'b1111, 32'h44444444);
        write_w(2, 32'h48, 4'b1111, 32'h48484848);
        for (int k = 0; k < 3; k++) begin
            read_w(2, 32'h40 + 32'(4 * k));
            @(posedge clk); #1;
        end

        // Address beyond the array: error with range checking, alias otherwise.
        write_w(0, 32'h0, 4'b1111, 32'h0BADF00D);
        read_w (0, 32'h10);
        write_w(0, 32'h1000, 4'b1111, 32'h77777777);
        read_w (0, 32'h1000);
        read_w (0, 32'h0);

        // Reset during WAIT aborts a pending write.
        write_w(0, 32'h4, 4'b1111, 32'h12345678);
        wait_idle(0);
        issue(0, 32'h4, 4'b1111, 32'hCAFEF00D, 1'b1);
        rstn = 1'b0;
        @(posedge clk); #1;
        rstn = 1'b1;
        for (int d = 0; d < NDUT; d++) begin
            busy[d] = 0;
            rd_model[d] = 32'h0;
        end
        check_eq("rst_mid_rdata", rdata[0], 32'h0);
        // Strobe in the first cycle after reset is accepted.
        issue(0, 32'h4, 4'b0000, 32'h0, 1'b0);
        read_w(0, 32'h10);

        for (int d = 0; d < NDUT; d++) wait_idle(d);
        repeat (4) @(posedge clk);
        #1;
        for (int d = 0; d < NDUT; d++) check_eq("pending_resp", 32'(exp_q[d].size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
